csr_access_ctrl: RTL and testbench
==================================

Name: csr_access_ctrl

Overview:
Sequences CSR instructions onto the shared CSR register bus (en/addr/set/clear in, read/ack out, with ack and read values OR-combined across all CSR register blocks). Arbitrates between two requesters: the trap unit (port T, fixed high priority) and the pipeline CSR stage (port P). Each access is a read phase followed by an optional write phase. Detects illegal accesses (unmapped address, write to read-only space) and returns old value or error to the granted requester.

Parameters:
ADDR_W, 12, CSR address width
DATA_W, 32, CSR data width
RO_CHECK, 1, when 1, writes to addr[11:10]==2'b11 are illegal

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous reset, active-low
t_req_i  input  1  trap unit request valid
t_op_i  input  2  trap op: 01 RW, 10 RS, 11 RC, 00 read-only
t_addr_i  input  ADDR_W  trap CSR address
t_wdata_i  input  DATA_W  trap write operand
t_gnt_o  output  1  trap request accepted this cycle
t_done_o  output  1  trap response valid, 1-cycle pulse
p_req_i  input  1  pipeline request valid
p_op_i  input  2  pipeline op, same encoding
p_addr_i  input  ADDR_W  pipeline CSR address
p_wdata_i  input  DATA_W  pipeline write operand
p_wzero_i  input  1  source is x0/zero immediate; suppresses the RS/RC write
p_gnt_o  output  1  pipeline request accepted this cycle
p_done_o  output  1  pipeline response valid, 1-cycle pulse
rdata_o  output  DATA_W  old CSR value, valid with *_done_o
illegal_o  output  1  access illegal, valid with *_done_o
csr_en_o  output  1  CSR bus enable
csr_addr_o  output  ADDR_W  CSR bus address
csr_set_o  output  DATA_W  bits to set
csr_clear_o  output  DATA_W  bits to clear
csr_read_i  input  DATA_W  OR of all CSR read values
csr_ack_i  input  1  OR of all CSR acks

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE; all outputs 0; latched request cleared.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - Grant if any request is pending; T wins ties.
  - Grant pulse is combinational in IDLE (gnt_o = req & selected).
  - Latch op/addr/wdata/wzero and owner; T wzero is 0.
  - Go to READ.
- READ (1 cycle):
  - csr_en_o=1, csr_addr_o=latched addr, set=0, clear=0.
  - Capture csr_read_i into rdata register.
  - illegal if !csr_ack_i, or (RO_CHECK & addr[11:10]==2'b11 & write_needed).
  - write_needed = op==RW | ((op==RS|op==RC) & !wzero).
  - Illegal or !write_needed -> RESP; otherwise -> WRITE.
- WRITE (1 cycle): csr_en_o=1, same addr.
  - RW: set=wdata, clear=~wdata.
  - RS: set=wdata, clear=0.
  - RC: set=0, clear=wdata.
  -> RESP.
- RESP (1 cycle): done_o of owner =1; rdata_o and illegal_o held valid; -> IDLE.
- Outside READ/WRITE: csr_en_o=0, csr_addr/set/clear=0. rdata_o/illegal_o are 0 when no done pulse.
- Latency, grant to done: 2 cycles for read-only or illegal access; 3 cycles with write.
- Back-to-back: a new grant is possible in the IDLE cycle after RESP; minimum issue interval is 3 or 4 cycles.
- Requests arriving mid-transaction wait (req held by requester); no preemption. A trap request during a pipeline access is served next.
- Requester may drop req without grant; nothing latched.
- Illegal access performs no write; CSR state is unchanged.
- Reset mid-transaction aborts immediately: no done pulse, bus idle.

Decomposition:
- Shared package csr_pkg:
  - op encodings CSR_OP_READ/RW/RS/RC.
  - state encoding.
  - RO address field constant (bits 11:10 == 2'b11).
- One natural sub-module: csr_mask_gen (combinational op+wdata -> set/clear).

Test Plan:
- P RW addr 0x340, wdata 0xA5A5_0000, CSR holding 0x1234_5678 -> read phase then write set=0xA5A5_0000 clear=0x5A5A_FFFF; p_done 3 cycles after grant; rdata_o=0x1234_5678; CSR becomes 0xA5A5_0000.
- P RS addr 0x340 with p_wzero_i=1 -> no WRITE cycle; done 2 cycles after grant; rdata_o = current value; CSR unchanged.
- T and P requesting in the same IDLE cycle -> t_gnt_o=1, p_gnt_o=0; T completes; P granted in the following IDLE cycle.
- P RW to unmapped address 0x7FF (csr_ack_i=0) -> illegal_o=1 with p_done_o; no WRITE cycle.
- P RC to 0xC00 with csr_ack_i=1, wdata 0x1 -> illegal_o=1, no write. Same address with op READ -> legal, rdata returned.
- Assert rst_i low during WRITE -> all outputs 0 asynchronously; no done pulse; after release the FSM is IDLE and accepts a new request.

Source files
------------

// File: rtl/csr_access_ctrl_pkg.sv
// Shared definitions for the CSR access controller.
//   csr_op_e    : CSR instruction op encoding (read-only / RW / RS / RC)
//   csr_state_e : controller FSM states
//   CSR_RO_FIELD: value of addr[11:10] that marks the read-only CSR space
//   csr_write_needed(): whether an op actually writes the CSR
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_OP_READ = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } csr_state_e;

    localparam logic [1:0] CSR_RO_FIELD = 2'b11;

    // RS/RC with a zero source (x0 or zero immediate) are pure reads.
    function automatic logic csr_write_needed(csr_op_e op, logic wzero);
        return (op == CSR_OP_RW) ||
               (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && !wzero);
    endfunction

endpackage

// File: rtl/csr_access_ctrl_if.sv
// Request/response and CSR register bus signals of the CSR access controller.
//   slave : controller view (requests and csr_read/csr_ack in, grants/responses/bus out)
//   master: environment view (trap unit, pipeline and CSR register blocks)
interface csr_access_ctrl_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    // trap unit port
    logic              t_req_i;
    logic [1:0]        t_op_i;
    logic [ADDR_W-1:0] t_addr_i;
    logic [DATA_W-1:0] t_wdata_i;
    logic              t_gnt_o;
    logic              t_done_o;
    // pipeline port
    logic              p_req_i;
    logic [1:0]        p_op_i;
    logic [ADDR_W-1:0] p_addr_i;
    logic [DATA_W-1:0] p_wdata_i;
    logic              p_wzero_i;
    logic              p_gnt_o;
    logic              p_done_o;
    // shared response
    logic [DATA_W-1:0] rdata_o;
    logic              illegal_o;
    // CSR register bus
    logic              csr_en_o;
    logic [ADDR_W-1:0] csr_addr_o;
    logic [DATA_W-1:0] csr_set_o;
    logic [DATA_W-1:0] csr_clear_o;
    logic [DATA_W-1:0] csr_read_i;
    logic              csr_ack_i;

    modport slave (
        input  t_req_i, t_op_i, t_addr_i, t_wdata_i,
        output t_gnt_o, t_done_o,
        input  p_req_i, p_op_i, p_addr_i, p_wdata_i, p_wzero_i,
        output p_gnt_o, p_done_o,
        output rdata_o, illegal_o,
        output csr_en_o, csr_addr_o, csr_set_o, csr_clear_o,
        input  csr_read_i, csr_ack_i
    );

    modport master (
        output t_req_i, t_op_i, t_addr_i, t_wdata_i,
        input  t_gnt_o, t_done_o,
        output p_req_i, p_op_i, p_addr_i, p_wdata_i, p_wzero_i,
        input  p_gnt_o, p_done_o,
        input  rdata_o, illegal_o,
        input  csr_en_o, csr_addr_o, csr_set_o, csr_clear_o,
        output csr_read_i, csr_ack_i
    );

endinterface

// File: rtl/csr_access_ctrl_mask_gen.sv
// csr_mask_gen: converts a CSR op and write operand into set/clear masks.
//   op_i    : CSR op
//   wdata_i : write operand
//   set_o   : bits to set
//   clear_o : bits to clear
module csr_mask_gen
    import csr_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  csr_op_e           op_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] set_o,
    output logic [DATA_W-1:0] clear_o
);

    always_comb begin
        set_o   = '0;
        clear_o = '0;
        unique case (op_i)
            CSR_OP_RW: begin
                set_o   = wdata_i;
                clear_o = ~wdata_i;
            end
            CSR_OP_RS: set_o   = wdata_i;
            CSR_OP_RC: clear_o = wdata_i;
            default:   ;
        endcase
    end

endmodule

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: arbitrates trap unit (T, high priority) and pipeline (P)
// CSR requests and sequences each onto the shared CSR bus as a read phase
// plus an optional write phase, flagging unmapped or read-only-space writes.
//   clk_i : clock
//   rst_i : asynchronous reset, active-low
//   bus   : request/response ports and CSR register bus (slave modport)
module csr_access_ctrl
    import csr_pkg::*;
#(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 32,
    parameter bit          RO_CHECK = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    csr_access_ctrl_if.slave     bus
);

    csr_state_e        state_q, state_d;
    csr_op_e           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              wzero_q;
    logic              owner_t_q;
    logic              illegal_q;

    logic              grant;
    logic              write_needed;
    logic              read_illegal;
    logic [DATA_W-1:0] mask_set, mask_clear;

    logic              t_gnt, p_gnt, t_done, p_done, illegal;
    logic              csr_en;
    logic [ADDR_W-1:0] csr_addr;
    logic [DATA_W-1:0] csr_set, csr_clear, rdata;

    assign grant        = (state_q == ST_IDLE) && (bus.t_req_i || bus.p_req_i);
    assign write_needed = csr_write_needed(op_q, wzero_q);
    assign read_illegal = !bus.csr_ack_i ||
                          (RO_CHECK && (addr_q[11:10] == CSR_RO_FIELD) && write_needed);

    csr_mask_gen #(.DATA_W(DATA_W)) u_mask_gen (
        .op_i    (op_q),
        .wdata_i (wdata_q),
        .set_o   (mask_set),
        .clear_o (mask_clear)
    );

    // state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (grant) state_d = ST_READ;
            ST_READ:  state_d = (read_illegal || !write_needed) ? ST_RESP : ST_WRITE;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // request latch and read-phase capture
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_q      <= CSR_OP_READ;
            addr_q    <= '0;
            wdata_q   <= '0;
            wzero_q   <= 1'b0;
            owner_t_q <= 1'b0;
            rdata_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (grant) begin
                owner_t_q <= bus.t_req_i;
                if (bus.t_req_i) begin
                    op_q    <= csr_op_e'(bus.t_op_i);
                    addr_q  <= bus.t_addr_i;
                    wdata_q <= bus.t_wdata_i;
                    wzero_q <= 1'b0;
                end else begin
                    op_q    <= csr_op_e'(bus.p_op_i);
                    addr_q  <= bus.p_addr_i;
                    wdata_q <= bus.p_wdata_i;
                    wzero_q <= bus.p_wzero_i;
                end
            end
            if (state_q == ST_READ) begin
                rdata_q   <= bus.csr_read_i;
                illegal_q <= read_illegal;
            end
        end
    end

    // outputs
    always_comb begin
        t_gnt     = 1'b0;
        p_gnt     = 1'b0;
        t_done    = 1'b0;
        p_done    = 1'b0;
        rdata     = '0;
        illegal   = 1'b0;
        csr_en    = 1'b0;
        csr_addr  = '0;
        csr_set   = '0;
        csr_clear = '0;
        unique case (state_q)
            ST_IDLE: begin
                // grants are combinational from req; gate with reset so
                // every output is 0 while reset is held
                t_gnt = rst_i && bus.t_req_i;
                p_gnt = rst_i && bus.p_req_i && !bus.t_req_i;
            end
            ST_READ: begin
                csr_en   = 1'b1;
                csr_addr = addr_q;
            end
            ST_WRITE: begin
                csr_en    = 1'b1;
                csr_addr  = addr_q;
                csr_set   = mask_set;
                csr_clear = mask_clear;
            end
            ST_RESP: begin
                t_done  = owner_t_q;
                p_done  = !owner_t_q;
                rdata   = rdata_q;
                illegal = illegal_q;
            end
            default: ;
        endcase
    end

    assign bus.t_gnt_o     = t_gnt;
    assign bus.p_gnt_o     = p_gnt;
    assign bus.t_done_o    = t_done;
    assign bus.p_done_o    = p_done;
    assign bus.rdata_o     = rdata;
    assign bus.illegal_o   = illegal;
    assign bus.csr_en_o    = csr_en;
    assign bus.csr_addr_o  = csr_addr;
    assign bus.csr_set_o   = csr_set;
    assign bus.csr_clear_o = csr_clear;

endmodule

// File: tb/tb_csr_access_ctrl.sv
module tb_csr_access_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    csr_access_ctrl_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    csr_access_ctrl #(.ADDR_W(12), .DATA_W(32), .RO_CHECK(1'b1)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    // CSR register blocks: 0x340 read/write, 0xC00 holds a constant-looking
    // value; anything else is unmapped (no ack).
    logic [31:0] reg340 = 32'h1234_5678;
    logic [31:0] regc00 = 32'hC0DE_0001;
    int          en_cnt = 0;

    always_comb begin
        bus.csr_read_i = '0;
        bus.csr_ack_i  = 1'b0;
        if (bus.csr_en_o) begin
            if (bus.csr_addr_o == 12'h340) begin
                bus.csr_read_i = reg340;
                bus.csr_ack_i  = 1'b1;
            end else if (bus.csr_addr_o == 12'hC00) begin
                bus.csr_read_i = regc00;
                bus.csr_ack_i  = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (bus.csr_en_o) en_cnt <= en_cnt + 1;
        if (bus.csr_en_o && bus.csr_addr_o == 12'h340)
            reg340 <= (reg340 & ~bus.csr_clear_o) | bus.csr_set_o;
        if (bus.csr_en_o && bus.csr_addr_o == 12'hC00)
            regc00 <= (regc00 & ~bus.csr_clear_o) | bus.csr_set_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction from T (t_side=1) or P; returns grant-to-done latency
    // (-1 if no done within the bound), response, last write masks seen and
    // number of bus-enable cycles.
    task automatic txn(input logic t_side, input logic [1:0] op, input logic [11:0] addr,
                       input logic [31:0] wd, input logic wz,
                       output int lat, output logic [31:0] rd, output logic ill,
                       output logic [31:0] set_seen, output logic [31:0] clr_seen,
                       output int ens);
        int en_start;
        @(negedge clk);
        en_start = en_cnt;
        if (t_side) begin
            bus.t_req_i = 1'b1; bus.t_op_i = op; bus.t_addr_i = addr; bus.t_wdata_i = wd;
        end else begin
            bus.p_req_i = 1'b1; bus.p_op_i = op; bus.p_addr_i = addr; bus.p_wdata_i = wd;
            bus.p_wzero_i = wz;
        end
        #1;
        chk("gnt_own",   t_side ? bus.t_gnt_o : bus.p_gnt_o, 1);
        chk("gnt_other", t_side ? bus.p_gnt_o : bus.t_gnt_o, 0);
        lat = -1; rd = '0; ill = 1'b0; set_seen = '0; clr_seen = '0;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.t_req_i = 1'b0;
                bus.p_req_i = 1'b0;
            end
            if (bus.csr_en_o && (bus.csr_set_o != 0 || bus.csr_clear_o != 0)) begin
                set_seen = bus.csr_set_o;
                clr_seen = bus.csr_clear_o;
            end
            if (t_side ? bus.t_done_o : bus.p_done_o) begin
                lat = c; rd = bus.rdata_o; ill = bus.illegal_o;
                break;
            end
        end
        ens = en_cnt - en_start;
    endtask

    int          lat, ens;
    logic [31:0] rd, sset, sclr;
    logic        ill;
    logic        got;

    initial begin
        bus.t_req_i = 1'b1; bus.t_op_i = 2'b00; bus.t_addr_i = '0; bus.t_wdata_i = '0;
        bus.p_req_i = 1'b1; bus.p_op_i = 2'b00; bus.p_addr_i = '0; bus.p_wdata_i = '0;
        bus.p_wzero_i = 1'b0;

        // reset state, with requests asserted
        repeat (2) @(negedge clk);
        chk("rst_t_gnt",  bus.t_gnt_o, 0);
        chk("rst_p_gnt",  bus.p_gnt_o, 0);
        chk("rst_done",   {bus.t_done_o, bus.p_done_o}, 0);
        chk("rst_bus_en", bus.csr_en_o, 0);
        chk("rst_rdata",  bus.rdata_o, 0);
        bus.t_req_i = 1'b0; bus.p_req_i = 1'b0;
        rst_n = 1'b1;

        // P RW 0x340
        txn(0, 2'b01, 12'h340, 32'hA5A5_0000, 0, lat, rd, ill, sset, sclr, ens);
        chk("rw_lat",   lat, 3);
        chk("rw_rdata", rd, 32'h1234_5678);
        chk("rw_ill",   ill, 0);
        chk("rw_set",   sset, 32'hA5A5_0000);
        chk("rw_clear", sclr, 32'h5A5A_FFFF);
        chk("rw_ens",   ens, 2);
        chk("rw_csr",   reg340, 32'hA5A5_0000);

        // P RS with zero source: read only
        txn(0, 2'b10, 12'h340, 32'hFFFF_FFFF, 1, lat, rd, ill, sset, sclr, ens);
        chk("rsz_lat",   lat, 2);
        chk("rsz_rdata", rd, 32'hA5A5_0000);
        chk("rsz_ens",   ens, 1);
        chk("rsz_csr",   reg340, 32'hA5A5_0000);

        // T RS sets low byte
        txn(1, 2'b10, 12'h340, 32'h0000_00FF, 0, lat, rd, ill, sset, sclr, ens);
        chk("trs_lat",   lat, 3);
        chk("trs_rdata", rd, 32'hA5A5_0000);
        chk("trs_clear", sclr, 32'h0000_0000);
        chk("trs_csr",   reg340, 32'hA5A5_00FF);

        // P RC clears low nibble
        txn(0, 2'b11, 12'h340, 32'h0000_000F, 0, lat, rd, ill, sset, sclr, ens);
        chk("prc_lat",  lat, 3);
        chk("prc_set",  sset, 32'h0000_0000);
        chk("prc_clear", sclr, 32'h0000_000F);
        chk("prc_csr",  reg340, 32'hA5A5_00F0);

        // T and P in the same IDLE cycle
        @(negedge clk);
        bus.t_req_i = 1'b1; bus.t_op_i = 2'b00; bus.t_addr_i = 12'h340; bus.t_wdata_i = '0;
        bus.p_req_i = 1'b1; bus.p_op_i = 2'b00; bus.p_addr_i = 12'h340; bus.p_wdata_i = '0;
        bus.p_wzero_i = 1'b0;
        #1;
        chk("arb_t_gnt", bus.t_gnt_o, 1);
        chk("arb_p_gnt", bus.p_gnt_o, 0);
        @(negedge clk);
        bus.t_req_i = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk("arb_p_wait", bus.p_gnt_o, 0);
            if (bus.t_done_o) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("arb_t_done", got, 1);
        chk("arb_t_rdata", bus.rdata_o, 32'hA5A5_00F0);
        chk("arb_p_done_idle", bus.p_done_o, 0);
        @(negedge clk);
        chk("arb_p_gnt_next", bus.p_gnt_o, 1);
        chk("arb_t_gnt_next", bus.t_gnt_o, 0);
        @(negedge clk);
        bus.p_req_i = 1'b0;
        @(negedge clk);
        chk("arb_p_done",  bus.p_done_o, 1);
        chk("arb_p_rdata", bus.rdata_o, 32'hA5A5_00F0);

        // unmapped address
        txn(0, 2'b01, 12'h7FF, 32'h1111_2222, 0, lat, rd, ill, sset, sclr, ens);
        chk("unm_lat", lat, 2);
        chk("unm_ill", ill, 1);
        chk("unm_ens", ens, 1);

        // write to read-only space
        txn(0, 2'b11, 12'hC00, 32'h0000_0001, 0, lat, rd, ill, sset, sclr, ens);
        chk("ro_lat", lat, 2);
        chk("ro_ill", ill, 1);
        chk("ro_csr", regc00, 32'hC0DE_0001);

        // read of read-only space
        txn(0, 2'b00, 12'hC00, 32'h0000_0001, 0, lat, rd, ill, sset, sclr, ens);
        chk("ror_lat",   lat, 2);
        chk("ror_ill",   ill, 0);
        chk("ror_rdata", rd, 32'hC0DE_0001);

        // reset during WRITE
        @(negedge clk);
        bus.p_req_i = 1'b1; bus.p_op_i = 2'b01; bus.p_addr_i = 12'h340;
        bus.p_wdata_i = 32'hFFFF_FFFF; bus.p_wzero_i = 1'b0;
        #1;
        chk("mid_gnt", bus.p_gnt_o, 1);
        @(negedge clk);
        bus.p_req_i = 1'b0;
        @(negedge clk);
        chk("mid_write_en", bus.csr_set_o, 32'hFFFF_FFFF);
        rst_n = 1'b0;
        #1;
        chk("mid_en",    bus.csr_en_o, 0);
        chk("mid_set",   bus.csr_set_o, 0);
        chk("mid_clear", bus.csr_clear_o, 0);
        chk("mid_addr",  bus.csr_addr_o, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid_no_done", {bus.t_done_o, bus.p_done_o}, 0);
        end
        chk("mid_csr", reg340, 32'hA5A5_00F0);
        rst_n = 1'b1;
        txn(0, 2'b00, 12'h340, 32'h0, 0, lat, rd, ill, sset, sclr, ens);
        chk("post_lat",   lat, 2);
        chk("post_rdata", rd, 32'hA5A5_00F0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
